input_event_encoder: RTL and testbench
======================================

Name: input_event_encoder

Overview:
- Front end between the board's raw switches/buttons and topControl.
- Synchronises and debounces every input, then turns button presses into single coded events.
- Presents events to topControl over a valid/ready handshake, with one pending slot per source.
- Switch inputs are delivered as clean, stable levels.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive cycles a synchronised input must differ from its stable value before the stable value flips (10 ms at 100 MHz); minimum 2.
- CNT_W, 20, width of each debounce counter; must hold DEBOUNCE_CYCLES-1.
- REPEAT_CYCLES, 25000000, auto-repeat period; used only with AUTO_REPEAT_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- act_bt  in  4  raw direction buttons: [0] up, [1] down, [2] left, [3] right
- rand_bt  in  1  raw shuffle button
- rst_bt  in  1  raw game-reset button
- st_sw  in  1  raw start switch
- bd_num_sw  in  5  raw board-number switches
- evt_ready  in  1  topControl accepts the current event
- evt_valid  out  1  event present
- evt_code  out  3  1=up, 2=down, 3=left, 4=right, 5=rand, 6=reset; 0 when idle
- evt_lost  out  1  one-cycle pulse: a press was dropped
- st_level  out  1  debounced st_sw
- bd_num  out  5  debounced bd_num_sw

Behaviour:
- Reset (rst=0, async): all sync flops, stable values, counters and pending bits = 0; evt_valid=0, evt_code=0, evt_lost=0, st_level=0, bd_num=0.
- Synchronisation: every raw bit passes through a 2-flop synchroniser.
- Debounce, single-bit inputs (6 buttons + st_sw, one counter each):
  - Counter clears whenever sync == stable.
  - Counter increments while sync != stable.
  - When the counter is at DEBOUNCE_CYCLES-1 and sync still differs, stable flips on that edge and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES never changes stable.
- Debounce, bd_num_sw: one shared counter for the 5-bit group. It clears whenever the synced vector changes or equals bd_num. bd_num updates as a whole vector.
- Edge detection: a 0->1 transition of a stable button sets that source's pending bit on the next edge. Releases produce nothing. st_sw never produces an event.
- Arbitration, when evt_valid=0 or a transfer completes this cycle:
  - Highest pending is selected by priority rst_bt > rand_bt > act[0] > act[1] > act[2] > act[3].
  - It is loaded into evt_code with evt_valid=1 and its pending bit is cleared on the same edge.
- Handshake:
  - A transfer occurs when evt_valid & evt_ready.
  - evt_code is held stable while valid & !ready.
  - A new event may load in the same cycle as a transfer (back-to-back, no bubble).
  - If nothing is pending after a transfer, evt_valid=0 and evt_code=0.
- Latency: raw change -> evt_valid = 2 + DEBOUNCE_CYCLES + 2 cycles when idle and ready.
- Overflow:
  - A new edge on a source whose pending bit is already set is dropped and evt_lost pulses for 1 cycle.
  - A new edge on the source currently held in evt_code only sets the pending bit (not lost).
- Simultaneous edges on several sources: all pending bits set; events are then emitted in priority order, one per transfer.
- Reset mid-handshake: evt_valid drops immediately and the pending event is discarded.

Optional Feature:
- Macro: AUTO_REPEAT_EN.
- Defined:
  - While a direction button's stable value stays 1, a per-direction repeat counter re-sets its pending bit every REPEAT_CYCLES cycles after the initial press.
  - A repeat that finds its pending bit already set is silently skipped; evt_lost does not pulse.
  - rand and reset never repeat.
- Undefined: one event per press; no repeat counters are synthesised.

Decomposition:
- Shared package (dd_pkg):
  - Event code constants EVT_NONE/UP/DOWN/LEFT/RIGHT/RAND/RESET (3 bits).
  - Default DEBOUNCE_CYCLES.
- Sub-module debounce_bit (sync + counter + stable register, parameterised DEBOUNCE_CYCLES/CNT_W), instantiated once per single-bit input.
- The top holds the bd_num group debouncer, edge detect, pending bits, arbiter and output register.

Test Plan:
- Use DEBOUNCE_CYCLES=4, REPEAT_CYCLES=16 throughout.
- act_bt[2] high for 10 cycles, evt_ready=1 -> evt_valid=1 with evt_code=3 exactly 8 cycles after the raw rise, for 1 cycle; no event on release.
- act_bt[0] glitch of 3 cycles -> no event; st_level and bd_num unchanged.
- rst_bt, rand_bt and act_bt[3] rise together, evt_ready=1 -> codes 6, 5, 4 on three consecutive cycles, then evt_valid=0.
- evt_ready=0, press up twice (separated by 20 cycles of release) while code 1 is held -> no evt_lost on the 2nd press; a 3rd press -> evt_lost pulses once; after evt_ready=1 -> codes 1, 1.
- bd_num_sw 0->5'b10110 with bit 0 bouncing for 2 cycles -> bd_num=22 only after 4 stable cycles; st_sw=1 -> st_level=1, no event.
- rst asserted while evt_valid=1 with code 2 -> evt_valid and evt_code are 0 before the next clock edge; with AUTO_REPEAT_EN, holding down for 40 cycles after debounce -> code 2 emitted 3 times.

Source files
------------

// File: rtl/dd_pkg.sv
// Shared definitions for the input event encoder: event codes, source indexing and
// the priority selection used by the arbiter.
package dd_pkg;

   localparam int DEBOUNCE_DEFAULT = 1000000;
   localparam int N_SRC            = 6;

   // Source index s (0..3 up/down/left/right, 4 rand, 5 reset) maps to event code s+1
   typedef enum logic [2:0] {
      EVT_NONE  = 3'd0,
      EVT_UP    = 3'd1,
      EVT_DOWN  = 3'd2,
      EVT_LEFT  = 3'd3,
      EVT_RIGHT = 3'd4,
      EVT_RAND  = 3'd5,
      EVT_RESET = 3'd6
   } evt_code_e;

   function automatic logic [2:0] pick_code(input logic [N_SRC-1:0] pend);
      if (pend[5]) return EVT_RESET;
      if (pend[4]) return EVT_RAND;
      if (pend[0]) return EVT_UP;
      if (pend[1]) return EVT_DOWN;
      if (pend[2]) return EVT_LEFT;
      if (pend[3]) return EVT_RIGHT;
      return EVT_NONE;
   endfunction

endpackage

// File: rtl/debounce_bit.sv
// Two-flop synchroniser followed by a counter debouncer for one raw input.
module debounce_bit
   import dd_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
   parameter int CNT_W           = 20
) (
   input  logic clk,
   input  logic rst,
   input  logic raw_i,
   output logic stable_o
);

   logic             sync1_q, sync2_q, stable_q;
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         stable_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync1_q <= raw_i;
         sync2_q <= sync1_q;
         if (sync2_q == stable_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            stable_q <= ~stable_q;
            cnt_q    <= '0;
         end else begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

   assign stable_o = stable_q;

endmodule

// File: rtl/input_event_encoder.sv
// Debounces board switches/buttons and presents button presses as coded events
// over valid/ready. Define AUTO_REPEAT_EN to add auto-repeat on held direction buttons.
module input_event_encoder
   import dd_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
   parameter int CNT_W           = 20
`ifdef AUTO_REPEAT_EN
   , parameter int REPEAT_CYCLES = 25000000
`endif
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] act_bt,
   input  logic       rand_bt,
   input  logic       rst_bt,
   input  logic       st_sw,
   input  logic [4:0] bd_num_sw,
   input  logic       evt_ready,
   output logic       evt_valid,
   output logic [2:0] evt_code,
   output logic       evt_lost,
   output logic       st_level,
   output logic [4:0] bd_num
);

   logic [6:0]       raw_in, stable;
   logic [4:0]       bd_s1_q, bd_s2_q, bd_q;
   logic [CNT_W-1:0] bd_cnt_q;
   logic [5:0]       stable_prev_q, rise, rep, clr, pend_q, pend_d;
   logic             valid_q, valid_d, lost_q, lost_d;
   logic [2:0]       code_q, code_d, sel_code;

   assign raw_in = {st_sw, rst_bt, rand_bt, act_bt};

   for (genvar gi = 0; gi < 7; gi++) begin : g_db
      debounce_bit #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .CNT_W          (CNT_W)
      ) u_db (
         .clk     (clk),
         .rst     (rst),
         .raw_i   (raw_in[gi]),
         .stable_o(stable[gi])
      );
   end

   // The board number is debounced as one vector so a partially settled value never shows
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bd_s1_q  <= '0;
         bd_s2_q  <= '0;
         bd_q     <= '0;
         bd_cnt_q <= '0;
      end else begin
         bd_s1_q <= bd_num_sw;
         bd_s2_q <= bd_s1_q;
         if (bd_s1_q != bd_s2_q || bd_s2_q == bd_q) begin
            bd_cnt_q <= '0;
         end else if (bd_cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            bd_q     <= bd_s2_q;
            bd_cnt_q <= '0;
         end else begin
            bd_cnt_q <= bd_cnt_q + CNT_W'(1);
         end
      end
   end

`ifdef AUTO_REPEAT_EN
   localparam int RPT_W = $clog2(REPEAT_CYCLES);

   for (genvar gd = 0; gd < 4; gd++) begin : g_rpt
      logic [RPT_W-1:0] cnt_q;
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            cnt_q <= '0;
         end else if (!stable[gd] || cnt_q == RPT_W'(REPEAT_CYCLES - 1)) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + RPT_W'(1);
         end
      end
      assign rep[gd] = stable[gd] && (cnt_q == RPT_W'(REPEAT_CYCLES - 1));
   end
   assign rep[5:4] = 2'b00;
`else
   assign rep = '0;
`endif

   assign rise = stable[5:0] & ~stable_prev_q;

   always_comb begin
      sel_code = pick_code(pend_q);
      clr      = '0;
      valid_d  = valid_q;
      code_d   = code_q;
      if (!valid_q || evt_ready) begin
         valid_d = (sel_code != EVT_NONE);
         code_d  = sel_code;
         if (sel_code != EVT_NONE) clr[sel_code - 3'd1] = 1'b1;
      end
      // A pending bit freed by this load can accept a new press without loss
      pend_d = (pend_q & ~clr) | rise | rep;
      lost_d = |(rise & pend_q & ~clr);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stable_prev_q <= '0;
         pend_q        <= '0;
         valid_q       <= 1'b0;
         code_q        <= EVT_NONE;
         lost_q        <= 1'b0;
      end else begin
         stable_prev_q <= stable[5:0];
         pend_q        <= pend_d;
         valid_q       <= valid_d;
         code_q        <= code_d;
         lost_q        <= lost_d;
      end
   end

   assign evt_valid = valid_q;
   assign evt_code  = code_q;
   assign evt_lost  = lost_q;
   assign st_level  = stable[6];
   assign bd_num    = bd_q;

endmodule

// File: tb/tb_input_event_encoder.sv
// Self-checking bench for input_event_encoder: directed scenarios plus random stimulus
// compared against a behavioural model of the debounce/pending/handshake rules.
module tb_input_event_encoder;

   localparam int DB  = 4;
   localparam int RPT = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] act_bt = '0;
   logic       rand_bt = 1'b0, rst_bt = 1'b0, st_sw = 1'b0;
   logic [4:0] bd_num_sw = '0;
   logic       evt_ready = 1'b0;
   logic       evt_valid, evt_lost, st_level;
   logic [2:0] evt_code;
   logic [4:0] bd_num;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   input_event_encoder #(
      .DEBOUNCE_CYCLES(DB),
      .CNT_W          (20)
`ifdef AUTO_REPEAT_EN
      , .REPEAT_CYCLES(RPT)
`endif
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .act_bt   (act_bt),
      .rand_bt  (rand_bt),
      .rst_bt   (rst_bt),
      .st_sw    (st_sw),
      .bd_num_sw(bd_num_sw),
      .evt_ready(evt_ready),
      .evt_valid(evt_valid),
      .evt_code (evt_code),
      .evt_lost (evt_lost),
      .st_level (st_level),
      .bd_num   (bd_num)
   );

   // Behavioural model. Source s: 0..3 directions, 4 rand, 5 reset, 6 start switch.
   bit         m_raw1 [7];
   bit         m_raw2 [7];
   bit         m_stab [7];
   int         m_streak [7];
   bit         m_press [6];
   bit         m_pend [6];
   int         m_hold [4];
   bit         m_valid, m_lost, m_was;
   bit         m_now [7];
   logic [2:0] m_code = '0;
   logic [4:0] b_raw1 = '0, b_raw2 = '0, m_bd = '0;
   int         b_streak, m_pick, m_idx;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int s = 0; s < 7; s++) begin
            m_raw1[s] = 0; m_raw2[s] = 0; m_stab[s] = 0; m_streak[s] = 0;
         end
         for (int s = 0; s < 6; s++) begin
            m_press[s] = 0; m_pend[s] = 0;
         end
         for (int s = 0; s < 4; s++) m_hold[s] = 0;
         m_valid = 0; m_lost = 0; m_code = '0;
         b_raw1 = '0; b_raw2 = '0; m_bd = '0; b_streak = 0;
      end else begin
         for (int s = 0; s < 4; s++) m_now[s] = act_bt[s];
         m_now[4] = rand_bt; m_now[5] = rst_bt; m_now[6] = st_sw;
         if (!m_valid || evt_ready) begin
            m_pick = -1;
            for (int p = 0; p < 6; p++) begin
               m_idx = (p < 2) ? 5 - p : p - 2;
               if (m_pick < 0 && m_pend[m_idx]) m_pick = m_idx;
            end
            if (m_pick >= 0) begin
               m_valid = 1; m_code = 3'(m_pick + 1); m_pend[m_pick] = 0;
            end else begin
               m_valid = 0; m_code = '0;
            end
         end
         m_lost = 0;
         for (int s = 0; s < 6; s++) begin
            if (m_press[s]) begin
               if (m_pend[s]) m_lost = 1;
               else m_pend[s] = 1;
            end
         end
`ifdef AUTO_REPEAT_EN
         for (int d = 0; d < 4; d++) begin
            if (m_stab[d]) begin
               m_hold[d]++;
               if (m_hold[d] % RPT == 0) m_pend[d] = 1;
            end else begin
               m_hold[d] = 0;
            end
         end
`endif
         for (int s = 0; s < 7; s++) begin
            m_was = m_stab[s];
            if (m_raw2[s] != m_stab[s]) begin
               m_streak[s]++;
               if (m_streak[s] == DB) begin
                  m_stab[s] = ~m_stab[s]; m_streak[s] = 0;
               end
            end else begin
               m_streak[s] = 0;
            end
            if (s < 6) m_press[s] = !m_was && m_stab[s];
            m_raw2[s] = m_raw1[s]; m_raw1[s] = m_now[s];
         end
         if (b_raw1 != b_raw2 || b_raw2 == m_bd) begin
            b_streak = 0;
         end else begin
            b_streak++;
            if (b_streak == DB) begin
               m_bd = b_raw2; b_streak = 0;
            end
         end
         b_raw2 = b_raw1; b_raw1 = bd_num_sw;
      end
   end

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", evt_valid); end
      checks++; if (evt_code !== 3'd0) begin errors++; $display("FAIL reset_code got %0d want 0", evt_code); end
      checks++; if (evt_lost !== 1'b0) begin errors++; $display("FAIL reset_lost got %b want 0", evt_lost); end
      checks++; if (st_level !== 1'b0) begin errors++; $display("FAIL reset_st got %b want 0", st_level); end
      checks++; if (bd_num !== 5'd0) begin errors++; $display("FAIL reset_bd got %0d want 0", bd_num); end
      rst = 1'b1;
   endtask

   task automatic test_single_press();
      logic       w_v;
      logic [2:0] w_c;
      @(negedge clk);
      evt_ready = 1'b1;
      act_bt[2] = 1'b1;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         w_v = (k == 8);
         w_c = w_v ? 3'd3 : 3'd0;
         checks++;
         if (evt_valid !== w_v || evt_code !== w_c) begin
            errors++;
            $display("FAIL press_left k=%0d got v=%b c=%0d want v=%b c=%0d", k, evt_valid, evt_code, w_v, w_c);
         end
         if (k == 10) act_bt[2] = 1'b0;
      end
   endtask

   task automatic test_glitch();
      @(negedge clk);
      act_bt[0] = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         checks++;
         if (evt_valid !== 1'b0 || st_level !== 1'b0 || bd_num !== 5'd0) begin
            errors++;
            $display("FAIL glitch k=%0d got v=%b st=%b bd=%0d want 0 0 0", k, evt_valid, st_level, bd_num);
         end
         if (k == 3) act_bt[0] = 1'b0;
      end
   endtask

   task automatic test_back_to_back();
      logic       w_v;
      logic [2:0] w_c;
      @(negedge clk);
      evt_ready = 1'b1;
      {rst_bt, rand_bt, act_bt[3]} = 3'b111;
      for (int k = 1; k <= 24; k++) begin
         @(negedge clk);
         w_v = (k >= 8 && k <= 10);
         w_c = (k == 8) ? 3'd6 : (k == 9) ? 3'd5 : (k == 10) ? 3'd4 : 3'd0;
         checks++;
         if (evt_valid !== w_v || evt_code !== w_c) begin
            errors++;
            $display("FAIL back_to_back k=%0d got v=%b c=%0d want v=%b c=%0d", k, evt_valid, evt_code, w_v, w_c);
         end
         if (k == 12) {rst_bt, rand_bt, act_bt[3]} = 3'b000;
      end
   endtask

   task automatic test_overflow();
      logic       w_v;
      logic [2:0] w_c;
      @(negedge clk);
      evt_ready = 1'b0;
      act_bt[0] = 1'b1;
      for (int k = 1; k <= 80; k++) begin
         @(negedge clk);
         checks++;
         if (evt_lost !== (k == 63)) begin
            errors++;
            $display("FAIL overflow_lost k=%0d got %b want %b", k, evt_lost, (k == 63));
         end
         w_v = (k >= 8);
         w_c = w_v ? 3'd1 : 3'd0;
         checks++;
         if (evt_valid !== w_v || evt_code !== w_c) begin
            errors++;
            $display("FAIL overflow_hold k=%0d got v=%b c=%0d want v=%b c=%0d", k, evt_valid, evt_code, w_v, w_c);
         end
         if (k == 8 || k == 36 || k == 64) act_bt[0] = 1'b0;
         if (k == 28 || k == 56) act_bt[0] = 1'b1;
      end
      evt_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (evt_valid !== 1'b1 || evt_code !== 3'd1) begin
         errors++;
         $display("FAIL overflow_second got v=%b c=%0d want v=1 c=1", evt_valid, evt_code);
      end
      @(negedge clk);
      checks++;
      if (evt_valid !== 1'b0 || evt_code !== 3'd0) begin
         errors++;
         $display("FAIL overflow_drain got v=%b c=%0d want v=0 c=0", evt_valid, evt_code);
      end
   endtask

   task automatic test_levels();
      logic [4:0] w_bd;
      @(negedge clk);
      bd_num_sw = 5'b10111;
      st_sw     = 1'b1;
      for (int k = 1; k <= 14; k++) begin
         @(negedge clk);
         w_bd = (k >= 9) ? 5'd22 : 5'd0;
         checks++;
         if (bd_num !== w_bd || st_level !== (k >= 6) || evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL levels k=%0d got bd=%0d st=%b v=%b want bd=%0d st=%b v=0", k, bd_num, st_level, evt_valid, w_bd, (k >= 6));
         end
         if (k == 1 || k == 3) bd_num_sw = 5'b10110;
         if (k == 2) bd_num_sw = 5'b10111;
      end
   endtask

   task automatic test_reset_mid();
      int k;
      @(negedge clk);
      evt_ready = 1'b0;
      act_bt[1] = 1'b1;
      k = 0;
      while (evt_valid !== 1'b1 && k < 20) begin
         @(negedge clk);
         k++;
      end
      checks++;
      if (evt_valid !== 1'b1 || evt_code !== 3'd2) begin
         errors++;
         $display("FAIL reset_mid_pre got v=%b c=%0d want v=1 c=2", evt_valid, evt_code);
      end
      act_bt[1] = 1'b0;
      #2 rst = 1'b0;
      #1;
      checks++;
      if (evt_valid !== 1'b0 || evt_code !== 3'd0) begin
         errors++;
         $display("FAIL reset_mid got v=%b c=%0d want v=0 c=0", evt_valid, evt_code);
      end
      @(negedge clk);
      rst = 1'b1;
      repeat (12) @(negedge clk);
   endtask

`ifdef AUTO_REPEAT_EN
   task automatic test_repeat();
      int n;
      @(negedge clk);
      evt_ready = 1'b1;
      act_bt[1] = 1'b1;
      n = 0;
      for (int k = 1; k <= 70; k++) begin
         @(negedge clk);
         if (evt_valid && evt_code == 3'd2) n++;
         if (k == 46) act_bt[1] = 1'b0;
      end
      checks++;
      if (n != 3) begin
         errors++;
         $display("FAIL repeat_count got %0d want 3", n);
      end
   endtask
`endif

   task automatic test_random();
      for (int c = 0; c < 2000 && errors < 20; c++) begin
         @(negedge clk);
         checks++;
         if (evt_valid !== m_valid || evt_code !== m_code || evt_lost !== m_lost ||
             st_level !== m_stab[6] || bd_num !== m_bd) begin
            errors++;
            $display("FAIL random c=%0d got v=%b c=%0d l=%b st=%b bd=%0d want v=%b c=%0d l=%b st=%b bd=%0d",
                     c, evt_valid, evt_code, evt_lost, st_level, bd_num,
                     m_valid, m_code, m_lost, m_stab[6], m_bd);
         end
         for (int b = 0; b < 4; b++) if ($urandom_range(7) == 0) act_bt[b] = ~act_bt[b];
         if ($urandom_range(9) == 0) rand_bt = ~rand_bt;
         if ($urandom_range(11) == 0) rst_bt = ~rst_bt;
         if ($urandom_range(9) == 0) st_sw = ~st_sw;
         if ($urandom_range(15) == 0) bd_num_sw = 5'($urandom);
         else if ($urandom_range(7) == 0) bd_num_sw[0] = ~bd_num_sw[0];
         evt_ready = 1'($urandom_range(1));
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_press();
      test_glitch();
      test_back_to_back();
      test_overflow();
      test_levels();
      test_reset_mid();
`ifdef AUTO_REPEAT_EN
      test_repeat();
`endif
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
